// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state codes,
// stream byte-order constants and small helper functions.
package imem_loader_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_CHK    = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    // Stream byte order: little-endian, least-significant byte of a word first
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] FIRST_BYTE_IDX = 2'd0;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'd3;

    // Running checksum: plain XOR of every data byte
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data_byte);
        return chk ^ data_byte;
    endfunction

    // Byte address of word number idx (wraps modulo 2^32)
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles stream bytes little-endian into 32-bit words and keeps the
// running XOR checksum of every byte shifted in.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        last_byte,
    output logic [7:0]  checksum
);

    logic [31:0] word_r;
    logic [1:0]  idx_r;
    logic [7:0]  chk_r;
    logic [31:0] word_next_s;

    // Word as it will look once the current byte lands in lane idx_r
    always_comb begin
        word_next_s = word_r;
        word_next_s[{idx_r, 3'b000} +: 8] = byte_in;
    end

    // Byte lane index, word shift register and checksum state
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_r <= 32'd0;
            idx_r  <= FIRST_BYTE_IDX;
            chk_r  <= 8'd0;
        end else if (shift_en) begin
            word_r <= word_next_s;
            idx_r  <= idx_r + 2'd1;
            chk_r  <= chk_update(chk_r, byte_in);
        end
    end

    assign word_next = word_next_s;
    assign last_byte = (idx_r == LAST_BYTE_IDX);
    assign checksum  = chk_r;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, XOR-checked byte
// stream, writes it word by word into instruction memory and holds the
// core until a complete verified program is present.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          LEN_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_data_in,
    output logic             mem_we,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_loaded
);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_full_s;
    logic [LEN_W-1:0] words_loaded_r;
    logic [31:0]      mem_address_r;
    logic [31:0]      mem_data_in_r;
    logic             byte_ready_r;
    logic             mem_we_r;
    logic             cpu_hold_r;
    logic             done_r;
    logic             err_r;
    logic             ready_next_s;
    logic             accept_s;
    logic             start_ok_s;
    logic             shift_en_s;
    logic [31:0]      word_next_s;
    logic             last_byte_s;
    logic [7:0]       checksum_s;

    assign accept_s   = byte_valid & byte_ready_r;
    assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERROR));
    assign shift_en_s = accept_s & (state_r == ST_DATA);
    assign len_full_s = LEN_W'({byte_in, len_r[7:0]});

    imem_word_packer u_packer (
        .clk       (CLK),
        .rst       (RST),
        .clear     (start_ok_s),
        .shift_en  (shift_en_s),
        .byte_in   (byte_in),
        .word_next (word_next_s),
        .last_byte (last_byte_s),
        .checksum  (checksum_s)
    );

    // Next-state decision for the load sequence
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) next_state_s = ST_LEN_LO;
                else       next_state_s = state_r;
            end
            ST_LEN_LO: begin
                if (accept_s) next_state_s = ST_LEN_HI;
                else          next_state_s = state_r;
            end
            ST_LEN_HI: begin
                if (!accept_s)                                next_state_s = state_r;
                else if (len_full_s == {LEN_W{1'b0}})         next_state_s = ST_CHK;
                else if (len_full_s > LEN_W'(MAX_WORDS))      next_state_s = ST_ERROR;
                else                                          next_state_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && last_byte_s) next_state_s = ST_WRITE;
                else                         next_state_s = state_r;
            end
            ST_WRITE: begin
                if (words_loaded_r + LEN_W'(1) == len_r) next_state_s = ST_CHK;
                else                                     next_state_s = ST_DATA;
            end
            ST_CHK: begin
                if (!accept_s)                  next_state_s = state_r;
                else if (byte_in == checksum_s) next_state_s = ST_DONE;
                else                            next_state_s = ST_ERROR;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // States in which the loader takes a stream byte
    always_comb begin
        ready_next_s = 1'b0;
        case (next_state_s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK: ready_next_s = 1'b1;
            default:                               ready_next_s = 1'b0;
        endcase
    end

    // State register, registered outputs and load bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= ST_IDLE;
            len_r          <= {LEN_W{1'b0}};
            words_loaded_r <= {LEN_W{1'b0}};
            mem_address_r  <= BASE_ADDR;
            mem_data_in_r  <= 32'd0;
            byte_ready_r   <= 1'b0;
            mem_we_r       <= 1'b0;
            cpu_hold_r     <= 1'b1;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            byte_ready_r <= ready_next_s;
            mem_we_r     <= (next_state_s == ST_WRITE);
            done_r       <= (next_state_s == ST_DONE);
            err_r        <= (next_state_s == ST_ERROR);
            cpu_hold_r   <= (next_state_s != ST_DONE);

            if (start_ok_s) begin
                words_loaded_r <= {LEN_W{1'b0}};
            end else if (state_r == ST_WRITE) begin
                words_loaded_r <= words_loaded_r + LEN_W'(1);
            end

            if (accept_s && (state_r == ST_LEN_LO)) begin
                len_r[7:0] <= byte_in;
            end else if (accept_s && (state_r == ST_LEN_HI)) begin
                len_r <= len_full_s;
            end

            // Address and data are latched on the 4th byte so WRITE sees them
            if (shift_en_s && last_byte_s) begin
                mem_address_r <= word_addr(BASE_ADDR, 32'(words_loaded_r));
                mem_data_in_r <= word_next_s;
            end
        end
    end

    assign byte_ready   = byte_ready_r;
    assign mem_address  = mem_address_r;
    assign mem_data_in  = mem_data_in_r;
    assign mem_we       = mem_we_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign err          = err_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader. A queue-based model turns a
// list of words into the byte stream and the expected memory writes.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .LEN_W(16)) dut (
        .CLK          (clk),
        .RST          (rst),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int checks = 0;
    int errors = 0;
    int tmo = 0;
    int bad_ready = 0;
    int bad_consec = 0;
    logic prev_we = 1'b0;
    logic [63:0] writes[$];
    logic [63:0] exp_writes[$];
    logic [31:0] tx_words[$];

    // Capture every memory write and watch write-cycle handshake rules
    always @(negedge clk) begin
        if (mem_we) begin
            writes.push_back({mem_address, mem_data_in});
            if (byte_ready) bad_ready++;
            if (prev_we) bad_consec++;
        end
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Offer one byte until accepted; with gaps, valid drops randomly
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sent;
        int n;
        sent = 1'b0;
        n = 0;
        while (!sent && n < 100) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_in = b;
            end
            sent = byte_valid && byte_ready;
            @(posedge clk);
            n++;
        end
        #1 byte_valid = 1'b0;
        if (!sent) tmo++;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, 64'(writes.size()), 64'(exp_writes.size()));
        for (int i = 0; i < exp_writes.size(); i++) begin
            if (i < writes.size()) begin
                check({tag, "_addr"}, 64'(writes[i][63:32]), 64'(exp_writes[i][63:32]));
                check({tag, "_data"}, 64'(writes[i][31:0]), 64'(exp_writes[i][31:0]));
            end
        end
    endtask

    // Full load of tx_words[0..len-1]; the model derives stream and outcome
    task automatic run_load(input string tag, input int len, input bit gaps,
                            input bit bad_chk, input bit poke_start);
        logic [15:0] len16;
        logic [7:0]  chk;
        logic [31:0] w;
        bit          ok;
        len16 = 16'(len);
        chk = 8'd0;
        ok = (len <= MAXW) && !bad_chk;
        exp_writes.delete();
        writes.delete();
        pulse_start();
        send_byte(len16[7:0], gaps);
        send_byte(len16[15:8], gaps);
        if (len <= MAXW) begin
            for (int i = 0; i < len; i++) begin
                w = tx_words[i];
                for (int k = 0; k < 4; k++) begin
                    chk = chk ^ w[7:0];
                    send_byte(w[7:0], gaps);
                    w = w >> 8;
                    if (poke_start && i == 0 && k == 0) pulse_start();
                end
                exp_writes.push_back({BASE + 32'(i) * 32'd4, tx_words[i]});
            end
            send_byte(bad_chk ? (chk ^ 8'hFF) : chk, gaps);
        end
        @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'(ok));
        check({tag, "_err"}, 64'(err), 64'(!ok));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(!ok));
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_wl"}, 64'(words_loaded), (len <= MAXW) ? 64'(len) : 64'd0);
        check_writes(tag);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_addr", 64'(mem_address), 64'(BASE));
        check("rst_data", 64'(mem_data_in), 64'd0);
        check("rst_wl", 64'(words_loaded), 64'd0);

        // Two-word load from the reference example
        tx_words = '{32'h44332211, 32'h88776655};
        run_load("two_word", 2, 1'b0, 1'b0, 1'b0);

        // Empty program: done right after the checksum byte
        tx_words.delete();
        run_load("len0", 0, 1'b0, 1'b0, 1'b0);

        // Oversize length field
        run_load("over", MAXW + 1, 1'b0, 1'b0, 1'b0);

        // Bad checksum on one word
        tx_words = '{32'hEFBEADDE};
        run_load("badchk", 1, 1'b0, 1'b1, 1'b0);

        // Same two-word case with random valid gaps and a stray start mid-load
        tx_words = '{32'h44332211, 32'h88776655};
        run_load("gaps", 2, 1'b1, 1'b0, 1'b1);

        // Random short programs with random gaps
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back($urandom);
            run_load("rand", n, 1'b1, 1'b0, 1'b0);
        end

        // Largest accepted program
        tx_words.delete();
        for (int i = 0; i < MAXW; i++) tx_words.push_back($urandom);
        run_load("maxw", MAXW, 1'b0, 1'b0, 1'b0);

        // Reset after the 6th data byte, with start asserted on the same edge
        tx_words = '{32'h44332211, 32'h88776655};
        writes.delete();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 6; k++) send_byte(8'(tx_words[k / 4] >> (8 * (k % 4))), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("midrst_nwrites", 64'(writes.size()), 64'd1);
        check("midrst_ready", 64'(byte_ready), 64'd0);
        check("midrst_hold", 64'(cpu_hold), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_wl", 64'(words_loaded), 64'd0);
        check("midrst_addr", 64'(mem_address), 64'(BASE));
        @(negedge clk);
        check("midrst_idle", 64'(byte_ready), 64'd0);

        // Reload after reset, then a clean repeat load from DONE
        tx_words = '{32'hCAFEF00D};
        run_load("reload", 1, 1'b0, 1'b0, 1'b0);
        tx_words = '{$urandom, $urandom, $urandom};
        run_load("repeat", 3, 1'b1, 1'b0, 1'b0);

        check("we_ready_low", 64'(bad_ready), 64'd0);
        check("we_single", 64'(bad_consec), 64'd0);
        check("no_timeouts", 64'(tmo), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
